mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port BIOS/instruction BRAM between three requesters: data port (LSU), instruction fetch, serial loader.
- Sits between the CPU pipeline/UART loader and the memory macro.
- Issues at most one access per cycle, returns read data after a fixed latency, prevents starvation, and supports an exclusive loader-lock mode for bootloading.

Parameters:
- ADDR_W, 12, word-address width
- DATA_W, 32, data width; byte enables are DATA_W/8
- MEM_LAT, 1, memory read latency in cycles (1..4)
- STARVE_LIMIT, 8, wait cycles before a requester is promoted to top priority

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req  in  3  request per requester; bit0 data, bit1 fetch, bit2 loader
- we  in  3  write flag per requester
- addr  in  3*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  packed write data
- be  in  3*DATA_W/8  packed byte enables
- gnt  out  3  one-hot; access accepted this cycle (combinational)
- rvalid  out  3  one-hot; read data valid for that requester
- rdata  out  DATA_W  read data, shared
- loader_lock  in  1  request exclusive loader access
- lock_active  out  1  exclusive mode in effect
- mem_en  out  1  memory enable
- mem_we  out  DATA_W/8  byte write enables
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data (valid MEM_LAT cycles after mem_en)
- stat_sel  in  2  statistics select (feature only)
- stat_cnt  out  32  statistics value (feature only)

Behaviour:
- Reset (rst==0 at posedge): gnt, rvalid, mem_en, mem_we, lock_active all 0; rdata 0; wait counters 0; state RUN; in-flight pipeline cleared. Reads in flight at reset are dropped; no rvalid is issued for them.
- Handshake:
  - Requester holds req/addr/we/wdata/be stable until it sees gnt in the same cycle.
  - A grant drives the memory that cycle: mem_en=1, mem_addr/mem_din from the winner, mem_we=be when we else 0.
- Read return: exactly MEM_LAT cycles after a read grant, rvalid[i]=1 for one cycle and rdata=mem_dout. Writes produce no rvalid.
  - Owner and read flag travel in a MEM_LAT-deep shift register.
  - Back-to-back grants return back-to-back rvalids in grant order.
- Priority in RUN:
  - Base order: data > fetch > loader.
  - Each requester has a wait counter, $clog2(STARVE_LIMIT+1) bits. It increments (saturating) each cycle req[i]=1 and gnt[i]=0, and clears on gnt[i] or req[i]=0.
  - A counter equal to STARVE_LIMIT makes that requester top priority. If several are starved, base order decides among them.
- State machine:
  - RUN: normal arbitration. loader_lock=1 goes to DRAIN.
  - DRAIN: no grants; wait until the in-flight pipeline is empty. Then go to LOCKED and set lock_active=1 (registered).
  - LOCKED: only req[2] may be granted, every cycle; req[0]/req[1] are ignored (gnt=0, counters held). loader_lock=0 goes to RUN after the cycle, clears lock_active, clears all wait counters.
  - loader_lock falling during DRAIN returns to RUN without entering LOCKED.
- Boundaries:
  - No req: mem_en=0, mem_we=0.
  - Requester dropping req without gnt: legal; no state kept.
  - Same requester granted every cycle: legal.
  - Write and a read return in the same cycle are independent.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: four 32-bit wrapping counters, cleared by reset.
  - Grants to data, grants to fetch, grants to loader.
  - Cycles with any req high but no grant (DRAIN/LOCKED blocking).
  - stat_cnt selects the counter by stat_sel, registered one cycle.
- Undefined: no counters; stat_cnt tied 0; stat_sel unused.

Decomposition:
- Shared package:
  - Requester index constants REQ_DATA=0, REQ_FETCH=1, REQ_LOADER=2, NUM_REQ=3.
  - State encoding ARB_RUN/ARB_DRAIN/ARB_LOCKED.
  - Stat-select constants.
- One sub-module, arb_priority_pick: combinational pick from req, starved mask, lock mask; one-hot out.
- The return shift register stays inline.

Test Plan:
- Reset: assert rst=0 for 5 cycles with req=3'b111 -> gnt=0, mem_en=0, rvalid=0. Release -> first grant is gnt=3'b001.
- Single read: fetch read addr 0x010, mem returns 0xDEADBEEF, MEM_LAT=1 -> gnt=3'b010 at cycle t, rvalid=3'b010 with rdata=0xDEADBEEF at t+1.
- Contention/starvation: data and fetch both request continuously, STARVE_LIMIT=8 -> data granted 8 cycles, fetch granted on cycle 9, then data again.
- Write: data write addr 0x004, wdata 0x12345678, be 4'b0011 -> mem_we=4'b0011, mem_din=0x12345678, no rvalid.
- Lock: loader_lock=1 while a fetch read is in flight -> that read's rvalid still issues, lock_active rises after drain. Then only loader granted despite req=3'b111. Lock release -> data granted next cycle.
- Stats (ARB_STATS_EN): 3 data, 2 fetch, 1 loader grants -> stat_sel 0/1/2 read 3/2/1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the BIOS/instruction BRAM port arbiter: requester
// indices, arbiter states and statistics selectors.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ    = 3;
  localparam int REQ_DATA   = 0;
  localparam int REQ_FETCH  = 1;
  localparam int REQ_LOADER = 2;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  localparam logic [1:0] STAT_DATA    = 2'd0;
  localparam logic [1:0] STAT_FETCH   = 2'd1;
  localparam logic [1:0] STAT_LOADER  = 2'd2;
  localparam logic [1:0] STAT_BLOCKED = 2'd3;

  // Isolates the lowest set bit; lowest index is the highest base priority.
  function automatic logic [NUM_REQ-1:0] lowest_one(input logic [NUM_REQ-1:0] v);
    return v & (~v + NUM_REQ'(1));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational one-hot pick: starved requesters first, then base order
// data > fetch > loader, both restricted to the currently allowed set.
module arb_priority_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] starved,
  input  logic [NUM_REQ-1:0] allow,
  output logic [NUM_REQ-1:0] pick
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] elig_starved;

  always_comb begin
    elig         = req & allow;
    elig_starved = elig & starved;
    pick         = (|elig_starved) ? lowest_one(elig_starved) : lowest_one(elig);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the single-port BIOS BRAM with fixed-latency read
// return, starvation promotion and loader lock. ARB_STATS_EN adds counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                we,
  input  logic [NUM_REQ*ADDR_W-1:0]         addr,
  input  logic [NUM_REQ*DATA_W-1:0]         wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]     be,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [NUM_REQ-1:0]                rvalid,
  output logic [DATA_W-1:0]                 rdata,
  input  logic                              loader_lock,
  output logic                              lock_active,
  output logic                              mem_en,
  output logic [DATA_W/8-1:0]               mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_din,
  input  logic [DATA_W-1:0]                 mem_dout,
  input  logic [1:0]                        stat_sel,
  output logic [31:0]                       stat_cnt
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e state_q, state_d;
  logic       lock_active_q, lock_active_d;

  logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [MEM_LAT:1][NUM_REQ-1:0] vld_pipe_q, vld_pipe_d;

  logic [NUM_REQ-1:0] allow;
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] pick;
  logic               pipe_empty;

  assign pipe_empty = ~|vld_pipe_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ARB_RUN;
      lock_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_active_q <= lock_active_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_RUN:    if (loader_lock) state_d = ARB_DRAIN;
      ARB_DRAIN:  begin
        if (!loader_lock)    state_d = ARB_RUN;
        else if (pipe_empty) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: if (!loader_lock) state_d = ARB_RUN;
      default:    state_d = ARB_RUN;
    endcase
  end

  // FSM: outputs (grant mask, registered lock flag)
  always_comb begin
    allow         = '0;
    lock_active_d = (state_d == ARB_LOCKED);
    unique case (state_q)
      ARB_RUN:    allow = '1;
      ARB_LOCKED: allow[REQ_LOADER] = 1'b1;
      default:    allow = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      starved[i] = (wait_cnt_q[i] == CNT_W'(STARVE_LIMIT));
  end

  arb_priority_pick u_pick (
    .req     (req),
    .starved (starved),
    .allow   (allow),
    .pick    (pick)
  );

  assign gnt = rst ? pick : '0;

  // Blocked data/fetch hold their age while locked so release does not
  // reorder them; the release cycle itself wipes every counter.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_cnt_d[i] = wait_cnt_q[i];
      if (state_q == ARB_LOCKED && !loader_lock)
        wait_cnt_d[i] = '0;
      else if (state_q == ARB_LOCKED && i != REQ_LOADER)
        wait_cnt_d[i] = wait_cnt_q[i];
      else if (!req[i] || gnt[i])
        wait_cnt_d[i] = '0;
      else if (!starved[i])
        wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
    end
  end

  always_comb begin
    mem_en   = |gnt;
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_addr = addr[i*ADDR_W +: ADDR_W];
        mem_din  = wdata[i*DATA_W +: DATA_W];
        mem_we   = we[i] ? be[i*BE_W +: BE_W] : '0;
      end
    end
  end

  // Read owner travels as a one-hot; a zero stage is a write or idle slot.
  always_comb begin
    vld_pipe_d[1] = gnt & ~we;
    for (int s = 2; s <= MEM_LAT; s++)
      vld_pipe_d[s] = vld_pipe_q[s-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      vld_pipe_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign rvalid      = rst ? vld_pipe_q[MEM_LAT] : '0;
  assign rdata       = (|rvalid) ? mem_dout : '0;
  assign lock_active = lock_active_q;

`ifdef ARB_STATS_EN
  logic [3:0][31:0] stat_q, stat_d;
  logic [31:0]      stat_cnt_q, stat_cnt_d;

  always_comb begin
    stat_d = stat_q;
    stat_d[STAT_DATA]    = stat_q[STAT_DATA]    + 32'(gnt[REQ_DATA]);
    stat_d[STAT_FETCH]   = stat_q[STAT_FETCH]   + 32'(gnt[REQ_FETCH]);
    stat_d[STAT_LOADER]  = stat_q[STAT_LOADER]  + 32'(gnt[REQ_LOADER]);
    stat_d[STAT_BLOCKED] = stat_q[STAT_BLOCKED] + 32'((|req) && !(|gnt));
    stat_cnt_d = stat_q[stat_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_q     <= '0;
      stat_cnt_q <= '0;
    end else begin
      stat_q     <= stat_d;
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter (MEM_LAT=1, STARVE_LIMIT=8).
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [3*BW-1:0] be;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          loader_lock, lock_active;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [1:0]    stat_sel;
  logic [31:0]   stat_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .loader_lock(loader_lock),
    .lock_active(lock_active), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  // Memory model: only the three addresses the requesters use are backed.
  logic [31:0] mem4 = 32'h0000_0044;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == '0) begin
        if (mem_addr == 12'h004)      mem_dout <= mem4;
        else if (mem_addr == 12'h010) mem_dout <= 32'hDEAD_BEEF;
        else if (mem_addr == 12'h020) mem_dout <= 32'hCAFE_F00D;
        else                          mem_dout <= '0;
      end else if (mem_addr == 12'h004) begin
        for (int b = 0; b < BW; b++)
          if (mem_we[b]) mem4[b*8 +: 8] <= mem_din[b*8 +: 8];
      end
    end
  end

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic        lock;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] rdata;
    logic        lock_active;
  } vec_t;

  vec_t tbl[$];

  localparam logic [2:0] D = 3'b001, F = 3'b010, L = 3'b100, N = 3'b000;
  localparam logic [31:0] V4 = 32'h0000_5678, VF = 32'hDEAD_BEEF, VL = 32'hCAFE_F00D;

  task automatic add(input string n, input logic r, input logic [2:0] rq, input logic [2:0] w,
                     input logic lk, input logic [2:0] eg, input logic [2:0] erv,
                     input logic [31:0] erd, input logic ela);
    vec_t v;
    v.name = n; v.rst = r; v.req = rq; v.we = w; v.lock = lk;
    v.gnt = eg; v.rvalid = erv; v.rdata = erd; v.lock_active = ela;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] eg, input logic [2:0] erv,
                       input logic [31:0] erd, input logic ela);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] ew;
    ea = '0; ed = '0; ew = '0;
    for (int i = 0; i < 3; i++) begin
      if (eg[i]) begin
        ea = addr[i*AW +: AW];
        ed = wdata[i*DW +: DW];
        ew = we[i] ? be[i*BW +: BW] : '0;
      end
    end
    n_vec++;
    if (gnt !== eg) begin
      n_miss++; $display("FAIL %s gnt got %b want %b", name, gnt, eg);
    end
    if (mem_en !== (|eg)) begin
      n_miss++; $display("FAIL %s mem_en got %b want %b", name, mem_en, |eg);
    end
    if (mem_we !== ew) begin
      n_miss++; $display("FAIL %s mem_we got %b want %b", name, mem_we, ew);
    end
    if ((|eg) && (mem_addr !== ea || mem_din !== ed)) begin
      n_miss++;
      $display("FAIL %s mem_addr/din got %h/%h want %h/%h", name, mem_addr, mem_din, ea, ed);
    end
    if (rvalid !== erv) begin
      n_miss++; $display("FAIL %s rvalid got %b want %b", name, rvalid, erv);
    end
    if (((|erv) || !rst) && rdata !== erd) begin
      n_miss++; $display("FAIL %s rdata got %h want %h", name, rdata, erd);
    end
    if (lock_active !== ela) begin
      n_miss++; $display("FAIL %s lock_active got %b want %b", name, lock_active, ela);
    end
  endtask

  task automatic step(input string n, input logic r, input logic [2:0] rq, input logic [2:0] w,
                      input logic lk, input logic [2:0] eg, input logic [2:0] erv,
                      input logic [31:0] erd, input logic ela);
    @(negedge clk);
    rst = r; req = rq; we = w; loader_lock = lk;
    #1;
    check(n, eg, erv, erd, ela);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] prev;
    logic [31:0] exp_stat [4];

    rst = 1'b0; req = 3'b111; we = '0; loader_lock = 1'b0; stat_sel = '0;
    addr  = {12'h020, 12'h010, 12'h004};
    wdata = {32'hA0A0_A0A0, 32'h0F0F_0F0F, 32'h1234_5678};
    be    = {4'hF, 4'hF, 4'b0011};

    for (int i = 0; i < 5; i++) add("reset", 0, 3'b111, N, 0, N, N, 0, 0);
    add("first_grant",     1, 3'b111, N, 0, D, N, 0,             0);
    add("rd_data_ret",     1, N,      N, 0, N, D, 32'h0000_0044, 0);
    add("rd_fetch",        1, F,      N, 0, F, N, 0,             0);
    add("rd_fetch_ret",    1, N,      N, 0, N, F, VF,            0);
    add("wr_data",         1, D,      D, 0, D, N, 0,             0);
    add("wr_no_rvalid",    1, N,      N, 0, N, N, 0,             0);
    add("rd_after_wr",     1, D,      N, 0, D, N, 0,             0);
    add("rd_after_wr_ret", 1, N,      N, 0, N, D, V4,            0);
    add("b2b_0",           1, 3'b011, N, 0, D, N, 0,             0);
    add("b2b_1",           1, F,      N, 0, F, D, V4,            0);
    add("b2b_ret",         1, N,      N, 0, N, F, VF,            0);
    add("wr_rd_0",         1, F,      N, 0, F, N, 0,             0);
    add("wr_rd_1",         1, D,      D, 0, D, F, VF,            0);
    add("wr_rd_2",         1, N,      N, 0, N, N, 0,             0);
    add("ld_rd",           1, L,      N, 0, L, N, 0,             0);
    add("ld_ret",          1, N,      N, 0, N, L, VL,            0);

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].lock,
           tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].lock_active);

    // Starvation: fetch wins every ninth cycle against continuous data.
    prev = N;
    for (int k = 0; k < 20; k++) begin
      logic [2:0] eg;
      eg = (k % 9 == 8) ? F : D;
      step("starve", 1, 3'b011, N, 0, eg, prev, (prev == D) ? V4 : VF, 0);
      prev = eg;
    end
    step("starve_tail", 1, N, N, 0, N, prev, (prev == D) ? V4 : VF, 0);

    // Lock with a fetch read in flight.
    step("lk_req",     1, F,      N, 1, F, N, 0,  0);
    step("lk_drain",   1, 3'b111, N, 1, N, F, VF, 0);
    step("lk_drain2",  1, 3'b111, N, 1, N, N, 0,  0);
    step("lk_on",      1, 3'b111, N, 1, L, N, 0,  1);
    step("lk_ld2",     1, 3'b111, N, 1, L, L, VL, 1);
    step("lk_release", 1, 3'b111, N, 0, L, L, VL, 1);
    step("lk_run",     1, 3'b111, N, 0, D, L, VL, 0);
    step("lk_tail",    1, N,      N, 0, N, D, V4, 0);

    // Lock dropped while draining.
    step("dr_req",  1, D,      N, 1, D, N, 0,  0);
    step("dr_drop", 1, 3'b011, N, 0, N, D, V4, 0);
    step("dr_run",  1, F,      N, 0, F, N, 0,  0);
    step("dr_tail", 1, N,      N, 0, N, F, VF, 0);

    // Reset with a read in flight drops its return.
    step("rs_req",  1, D, N, 0, D, N, 0, 0);
    step("rs_hold", 0, N, N, 0, N, N, 0, 0);
    step("rs_rel",  1, N, N, 0, N, N, 0, 0);

    // Grant mix for the statistics counters.
    step("st_d0", 1, D, N, 0, D, N, 0,  0);
    step("st_d1", 1, D, N, 0, D, D, V4, 0);
    step("st_d2", 1, D, N, 0, D, D, V4, 0);
    step("st_f0", 1, F, N, 0, F, D, V4, 0);
    step("st_f1", 1, F, N, 0, F, F, VF, 0);
    step("st_l0", 1, L, N, 0, L, F, VF, 0);
    step("st_end", 1, N, N, 0, N, L, VL, 0);

`ifdef ARB_STATS_EN
    exp_stat = '{3, 2, 1, 0};
`else
    exp_stat = '{0, 0, 0, 0};
`endif
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      stat_sel = 2'(s);
      @(negedge clk);
      #1;
      n_vec++;
      if (stat_cnt !== exp_stat[s]) begin
        n_miss++;
        $display("FAIL stat_sel=%0d stat_cnt got %0d want %0d", s, stat_cnt, exp_stat[s]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
